icache_direct: RTL and testbench
================================

Name: icache_direct

Overview:
- Direct-mapped, one-word-per-line instruction cache.
- Sits between the instruction fetch unit and the memory controller's instruction-read port.
- Serves fetch requests on a hit with one-cycle latency.
- On a miss, holds a word-read request to the memory controller until that controller signals completion, then fills the line and returns the instruction.

Parameters:
- INDEX_BITS, 6, line-index width; 2^INDEX_BITS lines.
- TAG_BITS, 30-INDEX_BITS, tag width; derived, never overridden.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global ready; when low, all registers hold
- clr  in  1  fetch flush (branch mispredict); drops the pending response
- fetch_valid  in  1  fetch request
- fetch_pc  in  32  fetch address; bits [1:0] ignored
- fetch_ready  out  1  cache can accept a request this cycle
- hit_valid  out  1  one-cycle pulse: hit_instr is valid
- hit_pc  out  32  address belonging to hit_instr
- hit_instr  out  32  instruction word
- mem_req  out  1  word-read request to the memory controller
- mem_addr  out  32  word address of the miss; {tag,index,2'b00}
- mem_done  in  1  memory controller completion pulse
- mem_data  in  32  read word; valid only in the cycle mem_done=1

Behaviour:
- Address split:
  - index = fetch_pc[INDEX_BITS+1:2]
  - tag = fetch_pc[31:INDEX_BITS+2]
- Storage: valid[], tag[] and data[] arrays.
- Reset:
  - valid[] all cleared; state=IDLE.
  - hit_valid=0, mem_req=0, mem_addr=0, hit_pc=0, hit_instr=0.
- rdy=0: no register changes; outputs hold their values; mem_done is ignored.
- States: IDLE, MISS.
- fetch_ready = (state==IDLE) && !rst. Combinational.
- Request acceptance: fetch_valid && fetch_ready on a clocked edge with rdy=1.
- IDLE, accepted request, hit (valid[index] && tag match):
  - Next cycle: hit_valid=1, hit_instr=data[index], hit_pc=fetch_pc.
  - State stays IDLE.
  - Back-to-back hits give one result per cycle.
- IDLE, accepted request, miss:
  - Next cycle: mem_req=1, mem_addr={fetch_pc[31:2],2'b00}, state=MISS.
  - hit_valid=0.
- MISS:
  - mem_req and mem_addr are held stable every cycle until mem_done is sampled high.
  - Stalls of any length are tolerated, including memory-controller preemption by load/store traffic.
- Edge with mem_done=1 in MISS:
  - data[index]<=mem_data, tag[index]<=tag, valid[index]<=1.
  - mem_req<=0, state<=IDLE.
  - hit_valid<=1, hit_instr<=mem_data, hit_pc<=mem_addr; suppressed if the miss was flushed.
- clr:
  - IDLE: hit_valid is forced to 0 on the next edge; any request in the same cycle is discarded.
  - MISS: mem_req is NOT dropped, because the controller's byte sequence cannot be aborted. The miss completes and fills the line, but the response is suppressed through an internal "killed" flag. killed is set by clr in MISS and cleared on return to IDLE.
- clr never invalidates lines; only rst does.
- mem_done while IDLE is ignored.
- A new request in the cycle mem_done fills is not accepted, because fetch_ready=0 in MISS. It is accepted from the following cycle.
- Same-index conflict: the fill overwrites the previous line unconditionally.

Optional Feature:
- Macro ICACHE_STATS_EN.
- Defined:
  - Adds outputs stat_hits[31:0] and stat_misses[31:0], both reset to 0.
  - Accepted hit increments stat_hits; accepted miss increments stat_misses.
  - Counters wrap at 2^32.
  - Counting happens under rdy=1 only; clr does not affect the counters.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Cold miss:
  - After reset, fetch 0x0000_0100.
  - Next cycle: mem_req=1, mem_addr=0x100.
  - Stall 4 cycles, then mem_done=1 with mem_data=0x00A00093.
  - Next cycle: hit_valid=1, hit_pc=0x100, hit_instr=0x00A00093, mem_req=0.
- Hit:
  - Refetch 0x100: hit_valid next cycle with 0x00A00093; mem_req stays 0.
  - Back-to-back fetches 0x100 then 0x100 give 2 consecutive hit pulses.
- Conflict:
  - INDEX_BITS=6: fetch 0x1100 (same index as 0x100, different tag) misses; fill with 0x12345678.
  - Refetch 0x100 misses again.
- Flush mid-miss:
  - Miss on 0x200, clr pulsed while mem_req=1.
  - mem_req stays high until mem_done=1; mem_data=0xDEADBEEF gives no hit_valid.
  - Later fetch 0x200 hits with 0xDEADBEEF.
- rdy low:
  - Deassert rdy during MISS for 3 cycles with mem_done pulsed: state, mem_req and mem_addr unchanged; the fill happens only on a mem_done seen with rdy=1.
- Reset mid-miss:
  - rst during MISS gives mem_req=0 and fetch_ready=1 next cycle.
  - Previously filled 0x100 now misses.
  - With ICACHE_STATS_EN: counters read 0.

Source files
------------

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache between the fetch unit
// and the memory controller's instruction-read port. Hits return one cycle
// after acceptance; misses hold a word-read request until mem_done, then
// fill the line and return the word. A flush during a miss lets the fill
// finish but suppresses the response.
// Optional feature: define ICACHE_STATS_EN to add hit/miss counters.
module icache_direct #(
  parameter  int INDEX_BITS = 6,
  localparam int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clr,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  output logic        fetch_ready,
  output logic        hit_valid,
  output logic [31:0] hit_pc,
  output logic [31:0] hit_instr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses
`endif
);

  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic {IDLE, MISS} state_e;

  state_e                state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic [31:0]           mem_addr_q, mem_addr_d;
  logic                  hit_valid_q, hit_valid_d;
  logic [31:0]           hit_pc_q, hit_pc_d;
  logic [31:0]           hit_instr_q, hit_instr_d;
  logic                  killed_q, killed_d;

  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [31:0]           data_q [LINES];

  logic [INDEX_BITS-1:0] req_idx, fill_idx;
  logic [TAG_BITS-1:0]   req_tag, fill_tag;
  logic                  lookup_hit, accept, fill;

  assign req_idx  = fetch_pc[INDEX_BITS+1:2];
  assign req_tag  = fetch_pc[31:INDEX_BITS+2];
  assign fill_idx = mem_addr_q[INDEX_BITS+1:2];
  assign fill_tag = mem_addr_q[31:INDEX_BITS+2];

  assign fetch_ready = (state_q == IDLE) && !rst;
  assign lookup_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  // A flush in the same cycle discards the request outright.
  assign accept      = fetch_valid && fetch_ready && !clr;
  assign fill        = (state_q == MISS) && mem_done;

  // Next-state and response logic for the IDLE/MISS controller.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    hit_valid_d = 1'b0;
    hit_pc_d    = hit_pc_q;
    hit_instr_d = hit_instr_q;
    killed_d    = killed_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (lookup_hit) begin
            hit_valid_d = 1'b1;
            hit_pc_d    = fetch_pc;
            hit_instr_d = data_q[req_idx];
          end else begin
            mem_req_d  = 1'b1;
            mem_addr_d = {fetch_pc[31:2], 2'b00};
            state_d    = MISS;
            killed_d   = 1'b0;
          end
        end
      end
      MISS: begin
        // The controller cannot abort a read, so a flush only marks it dead.
        if (clr) killed_d = 1'b1;
        if (mem_done) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          killed_d  = 1'b0;
          if (!(killed_q || clr)) begin
            hit_valid_d = 1'b1;
            hit_pc_d    = mem_addr_q;
            hit_instr_d = mem_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and response registers; rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      hit_valid_q <= 1'b0;
      hit_pc_q    <= '0;
      hit_instr_q <= '0;
      killed_q    <= 1'b0;
    end else if (rdy) begin
      // NOTE: sequential state uses non-blocking assignments so all
      // registers update together from pre-edge values.
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      hit_valid_q <= hit_valid_d;
      hit_pc_q    <= hit_pc_d;
      hit_instr_q <= hit_instr_d;
      killed_q    <= killed_d;
    end
  end

  // Line valid bits: cleared only by reset, set by a fill.
  always_ff @(posedge clk) begin
    if (rst)              valid_q           <= '0;
    else if (rdy && fill) valid_q[fill_idx] <= 1'b1;
  end

  // Tag and data arrays.
  always_ff @(posedge clk) begin
    // NOTE: tag/data arrays are not reset; valid_q gates every read of them.
    if (rdy && fill) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_data;
    end
  end

  assign hit_valid = hit_valid_q;
  assign hit_pc    = hit_pc_q;
  assign hit_instr = hit_instr_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] stat_hits_q, stat_misses_q;

  // Accepted-request counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hits_q   <= '0;
      stat_misses_q <= '0;
    end else if (rdy && accept) begin
      if (lookup_hit) stat_hits_q   <= stat_hits_q + 32'd1;
      else            stat_misses_q <= stat_misses_q + 32'd1;
    end
  end

  assign stat_hits   = stat_hits_q;
  assign stat_misses = stat_misses_q;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: expected hit responses go into a
// queue when the fetch/fill is driven and are popped when hit_valid pulses.
module tb_icache_direct;

  logic        clk = 1'b0;
  logic        rst, rdy, clr, fetch_valid, mem_done;
  logic [31:0] fetch_pc, mem_data;
  logic        fetch_ready, hit_valid, mem_req;
  logic [31:0] hit_pc, hit_instr, mem_addr;
`ifdef ICACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } resp_t;

  resp_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    mdl_hits = 0;
  int    mdl_misses = 0;

  icache_direct #(.INDEX_BITS(6)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready),
    .hit_valid(hit_valid), .hit_pc(hit_pc), .hit_instr(hit_instr),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_done(mem_done), .mem_data(mem_data)
`ifdef ICACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && hit_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_hit", {31'd0, hit_valid}, 32'd0);
      end else begin
        resp_t r;
        r = exp_q.pop_front();
        check("resp_pc", hit_pc, r.pc);
        check("resp_instr", hit_instr, r.instr);
      end
    end
  end

  task automatic do_hit(input logic [31:0] pc, input logic [31:0] instr);
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    exp_q.push_back('{pc: pc, instr: instr});
    mdl_hits++;
    tick();
    fetch_valid = 1'b0;
    check("hit_pulse", {31'd0, hit_valid}, 32'd1);
    check("hit_no_memreq", {31'd0, mem_req}, 32'd0);
  endtask

  task automatic do_miss(input logic [31:0] pc, input logic [31:0] data,
                         input int stall, input bit kill_mid);
    logic [31:0] waddr;
    waddr       = {pc[31:2], 2'b00};
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    mdl_misses++;
    tick();
    fetch_valid = 1'b0;
    check("miss_req", {31'd0, mem_req}, 32'd1);
    check("miss_addr", mem_addr, waddr);
    check("miss_not_ready", {31'd0, fetch_ready}, 32'd0);
    check("miss_no_hit", {31'd0, hit_valid}, 32'd0);
    for (int i = 0; i < stall; i++) begin
      clr = kill_mid && (i == 0);
      tick();
      clr = 1'b0;
      check("miss_req_held", {31'd0, mem_req}, 32'd1);
      check("miss_addr_held", mem_addr, waddr);
    end
    mem_done = 1'b1;
    mem_data = data;
    if (!kill_mid) exp_q.push_back('{pc: waddr, instr: data});
    tick();
    mem_done = 1'b0;
    check("fill_req_drop", {31'd0, mem_req}, 32'd0);
    check("fill_ready", {31'd0, fetch_ready}, 32'd1);
    check("fill_hit_valid", {31'd0, hit_valid}, {31'd0, !kill_mid});
  endtask

  task automatic check_stats();
`ifdef ICACHE_STATS_EN
    check("stat_hits", stat_hits, mdl_hits);
    check("stat_misses", stat_misses, mdl_misses);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; clr = 1'b0; fetch_valid = 1'b0;
    fetch_pc = '0; mem_done = 1'b0; mem_data = '0;
    tick();
    tick();
    check("rst_hit_valid", {31'd0, hit_valid}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_hit_pc", hit_pc, 32'd0);
    check("rst_hit_instr", hit_instr, 32'd0);
    check("rst_not_ready", {31'd0, fetch_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, fetch_ready}, 32'd1);
    check_stats();

    // Cold miss then hits.
    do_miss(32'h0000_0100, 32'h00A0_0093, 4, 1'b0);
    do_hit(32'h0000_0100, 32'h00A0_0093);

    // Back-to-back hits on consecutive cycles.
    fetch_valid = 1'b1;
    fetch_pc    = 32'h0000_0100;
    exp_q.push_back('{pc: 32'h100, instr: 32'h00A0_0093});
    exp_q.push_back('{pc: 32'h100, instr: 32'h00A0_0093});
    mdl_hits += 2;
    tick();
    check("b2b_hit0", {31'd0, hit_valid}, 32'd1);
    tick();
    fetch_valid = 1'b0;
    check("b2b_hit1", {31'd0, hit_valid}, 32'd1);
    tick();
    check("b2b_end", {31'd0, hit_valid}, 32'd0);

    // Same-index conflict evicts the old line.
    do_miss(32'h0000_1100, 32'h1234_5678, 2, 1'b0);
    do_miss(32'h0000_0100, 32'h00A0_0093, 1, 1'b0);

    // Flush mid-miss: fill happens, response suppressed.
    do_miss(32'h0000_0200, 32'hDEAD_BEEF, 3, 1'b1);
    do_hit(32'h0000_0200, 32'hDEAD_BEEF);

    // Flush in IDLE discards a same-cycle request that would hit.
    fetch_valid = 1'b1;
    fetch_pc    = 32'h0000_0200;
    clr         = 1'b1;
    tick();
    fetch_valid = 1'b0;
    clr         = 1'b0;
    check("clr_idle_no_hit", {31'd0, hit_valid}, 32'd0);
    check("clr_idle_no_req", {31'd0, mem_req}, 32'd0);

    // rdy low during a miss freezes the controller and ignores mem_done.
    fetch_valid = 1'b1;
    fetch_pc    = 32'h0000_0304;
    mdl_misses++;
    tick();
    fetch_valid = 1'b0;
    check("rdy_miss_req", {31'd0, mem_req}, 32'd1);
    rdy      = 1'b0;
    mem_done = 1'b1;
    mem_data = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rdy_lo_req", {31'd0, mem_req}, 32'd1);
      check("rdy_lo_addr", mem_addr, 32'h0000_0304);
      check("rdy_lo_state", {31'd0, fetch_ready}, 32'd0);
    end
    rdy      = 1'b1;
    mem_done = 1'b0;
    tick();
    check("rdy_hi_still_miss", {31'd0, mem_req}, 32'd1);
    mem_done = 1'b1;
    mem_data = 32'hCAFE_F00D;
    exp_q.push_back('{pc: 32'h304, instr: 32'hCAFE_F00D});
    tick();
    mem_done = 1'b0;
    check("rdy_fill_done", {31'd0, mem_req}, 32'd0);
    do_hit(32'h0000_0304, 32'hCAFE_F00D);

    // mem_done while IDLE must not touch the cache.
    mem_done = 1'b1;
    mem_data = 32'h1111_1111;
    tick();
    mem_done = 1'b0;
    check("idle_done_no_req", {31'd0, mem_req}, 32'd0);
    check("idle_done_no_hit", {31'd0, hit_valid}, 32'd0);
    do_hit(32'h0000_0304, 32'hCAFE_F00D);
    check_stats();

    // Reset in the middle of a miss.
    fetch_valid = 1'b1;
    fetch_pc    = 32'h0000_0400;
    tick();
    fetch_valid = 1'b0;
    check("rstmid_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    mdl_hits   = 0;
    mdl_misses = 0;
    check("rstmid_req_drop", {31'd0, mem_req}, 32'd0);
    check("rstmid_ready", {31'd0, fetch_ready}, 32'd1);
    check_stats();
    do_miss(32'h0000_0304, 32'h0000_0013, 1, 1'b0);
    check_stats();

    tick();
    tick();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
